// File: rtl/fcfs_grant_scheduler.sv
// fcfs_grant_scheduler: first-come-first-served arbiter for one shared resource.
// Requesters are granted strictly in arrival order, which is tracked in an internal
// order queue. Each requester holds at most one queue entry.
// Optional macro FCFS_GRANT_TIMEOUT_EN compiles in a hold timer that forcibly
// revokes a grant after MAX_HOLD cycles.
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   req            level request per requester
//   rel            release strobe per requester (only the owner's bit matters)
//   grant          registered one-hot grant
//   grant_vld      grant is non-zero
//   grant_id       index of the owner, 0 when idle (drives the resource mux select)
//   q_count        number of queued entries
//   timeout_pulse  one-cycle pulse after a forced revoke (0 without the macro)
module fcfs_grant_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned TMR_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld,
  output logic [ID_W-1:0]    grant_id,
  output logic [ID_W:0]      q_count,
  output logic               timeout_pulse
);

  localparam int unsigned QD    = 1 << ID_W;
  localparam int unsigned CNT_W = ID_W + 1;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8 || QD < NUM_REQ) begin : g_bad_req
    $error("fcfs_grant_scheduler: bad NUM_REQ/ID_W");
  end
  if (MAX_HOLD < 1 || MAX_HOLD >= (1 << TMR_W)) begin : g_bad_hold
    $error("fcfs_grant_scheduler: bad MAX_HOLD/TMR_W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    q_q [QD];
  logic [ID_W-1:0]    q_d [QD];
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_v;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] needs_low_q, needs_low_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               vld_q, vld_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] push_c;
  logic               pop_c;
  logic [ID_W-1:0]    head_c;
  logic               own_rel_c, own_req_c, hit_c;

`ifdef FCFS_GRANT_TIMEOUT_EN
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tpulse_q, tpulse_d;
  assign hit_c         = (timer_q == TMR_W'(MAX_HOLD - 1));
  assign timeout_pulse = tpulse_q;
`else
  assign hit_c         = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign head_c    = q_q[0];
  assign own_rel_c = rel[id_q];
  assign own_req_c = req[id_q];

  // Requesters eligible to join the order queue this edge.
  always_comb begin
    push_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      push_c[k] = req[k] & ~pending_q[k] & ~needs_low_q[k]
                & ~((state_q == GRANT) && (id_q == ID_W'(k)));
    end
  end

  // Next-state, grant and queue update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    vld_d       = vld_q;
    id_d        = id_q;
    pending_d   = pending_q;
    needs_low_d = needs_low_q & req;   // cleared by the first edge with req low
    pop_c       = 1'b0;
    q_d         = q_q;
    cnt_v       = cnt_q;
`ifdef FCFS_GRANT_TIMEOUT_EN
    timer_d     = timer_q;
    tpulse_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop_c             = 1'b1;
          pending_d[head_c] = 1'b0;
          // A withdrawn head is simply discarded; this costs one cycle.
          if (req[head_c]) begin
            grant_d = NUM_REQ'(1) << head_c;
            vld_d   = 1'b1;
            id_d    = head_c;
            state_d = GRANT;
`ifdef FCFS_GRANT_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end
      end
      GRANT: begin
        if (own_rel_c || !own_req_c || hit_c) begin
          grant_d           = '0;
          vld_d             = 1'b0;
          id_d              = '0;
          needs_low_d[id_q] = 1'b1;
          state_d           = RECOVER;
`ifdef FCFS_GRANT_TIMEOUT_EN
          // A genuine release on the same edge wins over the timeout.
          tpulse_d          = hit_c & ~own_rel_c & own_req_c;
`endif
        end else begin
`ifdef FCFS_GRANT_TIMEOUT_EN
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pop shifts the queue down; pushes then append in ascending index order.
    if (pop_c) begin
      for (int i = 0; i < QD - 1; i++) q_d[i] = q_q[i+1];
      q_d[QD-1] = '0;
      cnt_v     = cnt_v - 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (push_c[k]) begin
        q_d[cnt_v[ID_W-1:0]] = ID_W'(k);
        pending_d[k]         = 1'b1;
        cnt_v                = cnt_v + 1'b1;
      end
    end
    cnt_d = cnt_v;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      needs_low_q <= '0;
      grant_q     <= '0;
      vld_q       <= 1'b0;
      id_q        <= '0;
      for (int i = 0; i < QD; i++) q_q[i] <= '0;
`ifdef FCFS_GRANT_TIMEOUT_EN
      timer_q     <= '0;
      tpulse_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      needs_low_q <= needs_low_d;
      grant_q     <= grant_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      for (int i = 0; i < QD; i++) q_q[i] <= q_d[i];
`ifdef FCFS_GRANT_TIMEOUT_EN
      timer_q     <= timer_d;
      tpulse_q    <= tpulse_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_vld = vld_q;
  assign grant_id  = id_q;
  assign q_count   = cnt_q;

endmodule
